// File: rtl/map_sched_pkg.sv
// Shared constants, state encoding and small arithmetic helpers for the
// circle-map scheduler.
package map_sched_pkg;

    localparam int MAP_DIM  = 8;
    localparam int CIRCLE_W = 12;
    localparam int FIELD_W  = 4;
    localparam int CX_LSB   = 8;
    localparam int CY_LSB   = 4;
    localparam int RAD_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Unsigned |a - b| for 4-bit operands.
    function automatic logic [FIELD_W-1:0] abs_diff4(input logic [FIELD_W-1:0] a,
                                                     input logic [FIELD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Exact square of a 4-bit value (0..225).
    function automatic logic [2*FIELD_W-1:0] square4(input logic [FIELD_W-1:0] v);
        return {4'b0, v} * {4'b0, v};
    endfunction

endpackage

// File: rtl/circle_row_eval.sv
// Combinational coverage test of one map row against one circle.
// Bit i of row_bits is set when cell (x=i+1, y=row+1) lies inside or on the circle.
module circle_row_eval
    import map_sched_pkg::*;
(
    input  logic [CIRCLE_W-1:0] circle,
    input  logic [2:0]          row,
    output logic [MAP_DIM-1:0]  row_bits
);

    logic [FIELD_W-1:0]   cx;
    logic [FIELD_W-1:0]   cy;
    logic [FIELD_W-1:0]   rad;
    logic [FIELD_W-1:0]   y;
    logic [FIELD_W-1:0]   dy;
    logic [2*FIELD_W-1:0] dy2;
    logic [2*FIELD_W-1:0] r2;

    assign cx  = circle[CX_LSB  +: FIELD_W];
    assign cy  = circle[CY_LSB  +: FIELD_W];
    assign rad = circle[RAD_LSB +: FIELD_W];
    assign y   = {1'b0, row} + 4'd1;
    assign dy  = abs_diff4(y, cy);
    assign dy2 = square4(dy);
    assign r2  = square4(rad);

    // One distance comparator per column; the 9-bit sum never truncates.
    for (genvar i = 0; i < MAP_DIM; i++) begin : g_col
        logic [FIELD_W-1:0]   dx;
        logic [2*FIELD_W:0]   dist2;
        assign dx          = abs_diff4(4'(i + 1), cx);
        assign dist2       = {1'b0, square4(dx)} + {1'b0, dy2};
        assign row_bits[i] = (dist2 <= {1'b0, r2});
    end

endmodule

// File: rtl/map_scheduler.sv
// Circle-map scheduler: buffers up to MAX_CIRCLES circles, then on start
// rasterises them one row per cycle into an 8x8 coverage map.
// Optional feature: define MAP_SCHED_COVER_CNT_EN to add the cover_cnt output
// (population count of the finished map).
module map_scheduler
    import map_sched_pkg::*;
#(
    parameter int MAX_CIRCLES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                circle_valid,
    input  logic [CIRCLE_W-1:0] circle_data,
    output logic                circle_ready,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic [2:0]          rd_row,
    output logic [MAP_DIM-1:0]  rd_data
`ifdef MAP_SCHED_COVER_CNT_EN
    ,
    output logic [6:0]          cover_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_CIRCLES + 1);
    localparam int IDX_W = (MAX_CIRCLES > 1) ? $clog2(MAX_CIRCLES) : 1;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     c;
    logic [2:0]           r;
    logic [MAP_DIM-1:0]   map [MAP_DIM];
    logic [CIRCLE_W-1:0]  circle_buf [MAX_CIRCLES];
    logic [MAP_DIM-1:0]   row_bits;
    logic                 push_acc;
    logic                 start_acc;
    logic                 last_step;

    assign push_acc  = circle_valid && circle_ready;
    assign start_acc = (state == IDLE) && start;
    assign last_step = (r == 3'd7) && (c == count - CNT_W'(1));

    circle_row_eval u_row_eval (
        .circle   (circle_buf[IDX_W'(c)]),
        .row      (r),
        .row_bits (row_bits)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a push in the same cycle as start counts toward the scan.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (count == '0 && !push_acc) ? DONE : SCAN;
            SCAN: if (last_step) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        circle_ready = (state == IDLE) && (count < CNT_W'(MAX_CIRCLES));
        busy         = (state == SCAN) || (state == DONE);
        done         = (state == DONE);
    end

    // Circle storage; entries at or above count are never read.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is deliberately not reset; count alone defines valid entries.
        if (push_acc) begin
            circle_buf[IDX_W'(count)] <= circle_data;
        end
    end

    // Counters and map accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            c     <= '0;
            r     <= '0;
            for (int i = 0; i < MAP_DIM; i++) map[i] <= '0;
        end else begin
            if (push_acc) count <= count + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        c <= '0;
                        r <= '0;
                        for (int i = 0; i < MAP_DIM; i++) map[i] <= '0;
                    end
                end
                SCAN: begin
                    map[r] <= map[r] | row_bits;
                    r      <= r + 3'd1;
                    if (r == 3'd7) c <= c + CNT_W'(1);
                end
                DONE: begin
                    count <= '0;
                end
                default: ;
            endcase
        end
    end

    assign rd_data = map[rd_row];

`ifdef MAP_SCHED_COVER_CNT_EN
    logic [6:0] map_pop;

    // Population count of the whole map.
    always_comb begin
        map_pop = '0;
        for (int i = 0; i < MAP_DIM; i++) begin
            for (int j = 0; j < MAP_DIM; j++) begin
                map_pop = map_pop + 7'(map[i][j]);
            end
        end
    end

    // Capture coverage when the map completes; clear on a new scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cover_cnt <= '0;
        end else if (start_acc) begin
            cover_cnt <= '0;
        end else if (state == DONE) begin
            cover_cnt <= map_pop;
        end
    end
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_map_scheduler.sv
// Directed bench for map_scheduler with hand-computed map images.
// Map images are packed as {row7, row6, ..., row0}.
`timescale 1ns/1ps
module tb_map_scheduler;

    localparam int MAX_C = 8;

    logic        clk;
    logic        rst_n;
    logic        circle_valid;
    logic [11:0] circle_data;
    logic        circle_ready;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  rd_row;
    logic [7:0]  rd_data;
`ifdef MAP_SCHED_COVER_CNT_EN
    logic [6:0]  cover_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cycles;
    bit saw_done;
    int dcount;

    map_scheduler #(.MAX_CIRCLES(MAX_C)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .circle_valid (circle_valid),
        .circle_data  (circle_data),
        .circle_ready (circle_ready),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .rd_row       (rd_row),
        .rd_data      (rd_data)
`ifdef MAP_SCHED_COVER_CNT_EN
        ,
        .cover_cnt    (cover_cnt)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_map(input string tag, input logic [63:0] exp);
        for (int i = 0; i < 8; i++) begin
            rd_row = 3'(i);
            #1;
            check($sformatf("%s_row%0d", tag, i), 32'(rd_data), 32'(exp[i*8 +: 8]));
        end
    endtask

    task automatic push(input logic [11:0] d);
        @(negedge clk);
        circle_valid = 1'b1;
        circle_data  = d;
        @(posedge clk);
        #1;
        circle_valid = 1'b0;
    endtask

    // Starts a scan (optionally with a same-edge push), counts busy cycles
    // before done, and optionally pokes start+push at scan cycle 'poke'.
    task automatic run_scan(input logic with_push, input logic [11:0] pdata,
                            input int poke, output int n_cyc, output bit got_done);
        @(negedge clk);
        start        = 1'b1;
        circle_valid = with_push;
        circle_data  = pdata;
        @(posedge clk);
        #1;
        start        = 1'b0;
        circle_valid = 1'b0;
        n_cyc        = 0;
        got_done     = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (n_cyc == poke) begin
                start        = 1'b1;
                circle_valid = 1'b1;
                circle_data  = 12'h180;
            end else begin
                start        = 1'b0;
                circle_valid = 1'b0;
            end
            if (busy) n_cyc++;
            @(posedge clk);
            #1;
        end
        start        = 1'b0;
        circle_valid = 1'b0;
        check("done_seen", 32'(got_done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("ready_after_done", 32'(circle_ready), 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        circle_valid = 1'b0;
        circle_data  = '0;
        start        = 1'b0;
        rd_row       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(circle_ready), 32'd1);
        check_map("rst_map", 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single point circle at (4,4).
        push(12'h440);
        run_scan(1'b0, 12'h0, -1, cycles, saw_done);
        check("t1_scan_len", 32'(cycles), 32'd8);
        check_map("t1", {8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00});
`ifdef MAP_SCHED_COVER_CNT_EN
        check("t1_cover", 32'(cover_cnt), 32'd1);
`endif

        // Radius 2 at (4,4): diamond-like disc of 13 cells.
        push(12'h442);
        run_scan(1'b0, 12'h0, -1, cycles, saw_done);
        check("t2_scan_len", 32'(cycles), 32'd8);
        check_map("t2", {8'h00, 8'h00, 8'h08, 8'h1C, 8'h3E, 8'h1C, 8'h08, 8'h00});
`ifdef MAP_SCHED_COVER_CNT_EN
        check("t2_cover", 32'(cover_cnt), 32'd13);
`endif

        // Two corner circles clipped by the map edge.
        push(12'h111);
        push(12'h881);
        run_scan(1'b0, 12'h0, -1, cycles, saw_done);
        check("t3_scan_len", 32'(cycles), 32'd16);
        check_map("t3", {8'hC0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03});
        // Map must stay put while idle.
        repeat (3) @(posedge clk);
        #1;
        rd_row = 3'd7;
        #1;
        check("t3_hold_row7", 32'(rd_data), 32'hC0);
`ifdef MAP_SCHED_COVER_CNT_EN
        check("t3_cover", 32'(cover_cnt), 32'd6);
`endif

        // Empty buffer: done immediately, map cleared.
        run_scan(1'b0, 12'h0, -1, cycles, saw_done);
        check("t4_empty_scan_len", 32'(cycles), 32'd0);
        check_map("t4", 64'h0);

        // Fill the buffer with diagonal points; the extra push must be dropped.
        for (int k = 0; k < MAX_C; k++) begin
            check($sformatf("fill_ready%0d", k), 32'(circle_ready), 32'd1);
            push({4'(k + 1), 4'(k + 1), 4'd0});
        end
        check("full_ready", 32'(circle_ready), 32'd0);
        push(12'h180);
        run_scan(1'b0, 12'h0, -1, cycles, saw_done);
        check("t5_scan_len", 32'(cycles), 32'd64);
        check_map("t5", {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01});
`ifdef MAP_SCHED_COVER_CNT_EN
        check("t5_cover", 32'(cover_cnt), 32'd8);
`endif

        // Push and start in the same edge; start and push during SCAN ignored.
        run_scan(1'b1, 12'h440, 3, cycles, saw_done);
        check("t6_scan_len", 32'(cycles), 32'd8);
        check_map("t6", {8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00});

        // Reset in the middle of a scan.
        push(12'h442);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t7_busy", 32'(busy), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        rd_row = 3'd3;
        #1;
        check("t7_partial_row3", 32'(rd_data), 32'h3E);
        rd_row = 3'd4;
        #1;
        check("t7_partial_row4", 32'(rd_data), 32'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_done", 32'(done), 32'd0);
        check("t7_rst_ready", 32'(circle_ready), 32'd1);
        check_map("t7_rst", 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) dcount++;
        end
        check("t7_no_done", 32'(dcount), 32'd0);
        run_scan(1'b0, 12'h0, -1, cycles, saw_done);
        check("t7_buffer_discarded", 32'(cycles), 32'd0);
        check_map("t7_after", 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
